exec_ctrl: RTL and testbench
============================

EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning datapath width of operand, accumulator and ALU buses.
REQ-002 SHALL have port clk  input  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports instr_valid input 1, instr_ready output 1, instr_op input 8 (shared opcode set), instr_arg input WIDTH (immediate or address).
REQ-005 SHALL have ports alu_in1 output WIDTH, alu_in2 output WIDTH, alu_op output 8, alu_out input WIDTH, all to/from the downstream ALU.
REQ-006 SHALL have ports mem_addr output WIDTH, mem_wdata output WIDTH, mem_rdata input WIDTH, mem_rd output 1, mem_wr output 1, io_rd output 1, io_wr output 1.
REQ-007 SHALL have ports acc output WIDTH (accumulator), flag_z output 1 (acc==0), flag_n output 1 (acc MSB), busy output 1 (state != IDLE).

Function
REQ-008 SHALL implement FSM states IDLE, RD, EXEC, WR; instr_ready=1 only in IDLE.
REQ-009 SHALL accept an instruction on a rising edge with instr_valid=1 in IDLE, latching instr_op and instr_arg into op_r/arg_r.
REQ-010 SHALL route from IDLE: XOR/OR/AND/SUB/ADD/LD/IOR -> RD; ST/IOW -> WR; all other opcodes (including unknown) -> EXEC.
REQ-011 SHALL in RD assert mem_rd (IOR: io_rd instead) for exactly one cycle with mem_addr=arg_r, then go to EXEC.
REQ-012 SHALL in EXEC drive alu_op=op_r, alu_in1=arg_r for LDI else acc, alu_in2=mem_rdata if entered from RD else arg_r, and return to IDLE.
REQ-013 SHALL outside EXEC drive alu_op=NOP opcode, alu_in1=acc, alu_in2=arg_r.
REQ-014 SHALL write acc<=alu_out at the end of EXEC only for NOT, XOR, OR, AND, SUB, ADD, RR, RL, DEC, INC, LD, IOR, LDI, RST; JMP/JMA/CLL/RET/NOP/unknown leave acc unchanged.
REQ-015 SHALL in WR assert mem_wr (IOW: io_wr) for exactly one cycle with mem_addr=arg_r, mem_wdata=acc, then return to IDLE; acc unchanged.
REQ-016 SHALL assume mem_rdata valid in the cycle after the mem_rd/io_rd cycle (1-cycle read latency).
REQ-017 SHALL give latency from acceptance edge to acc update: 1 cycle for register-only ops, 2 cycles for RD-path ops; ST/IOW ready again 1 cycle after acceptance.
REQ-018 SHALL keep mem_rd, mem_wr, io_rd, io_wr mutually exclusive and 0 in IDLE and EXEC.
REQ-019 SHALL update flag_z and flag_n registered, together with each acc write, from the value written; unchanged otherwise.
REQ-020 SHALL use modulo-2^WIDTH arithmetic as produced by the ALU; no saturation, no carry flag.
REQ-021 SHALL ignore instr_valid while busy; upstream holds instr_op/instr_arg until instr_ready.
REQ-022 SHALL hold mem_addr=arg_r and mem_wdata=acc combinationally in all states.

Reset
REQ-023 SHALL on rst_n=0 immediately force state=IDLE, acc=0, op_r=NOP, arg_r=0, flag_z=1, flag_n=0, all strobes 0, independent of clk.
REQ-024 SHALL abort any in-flight instruction on reset with no acc or memory write completing; first acceptance possible on first rising edge after rst_n=1.

Structure
REQ-025 SHALL take opcode values exclusively from the shared instructions include file; FSM state encoding stays local.
REQ-026 SHALL place opcode classification (needs_read, needs_write, writes_acc, is_io) in one combinational sub-module exec_decode.
REQ-027 SHALL not instantiate the ALU; the top level connects exec_ctrl to it.

Verification
REQ-028 SHALL test reset: rst_n low mid-RD -> strobes 0 same cycle, acc=0, flag_z=1, instr_ready=1.
REQ-029 SHALL test LDI arg=0x1234 -> alu_in1=0x1234 in EXEC, acc=0x1234 one cycle later, flag_z=0, flag_n=0.
REQ-030 SHALL test acc=0x0005, ADD arg=0x0010, mem[0x0010]=0x0003 -> mem_rd one cycle at addr 0x0010, acc=0x0008 two cycles after acceptance.
REQ-031 SHALL test acc=0x8000, ST arg=0x0020 -> mem_wr one cycle, mem_wdata=0x8000, acc unchanged, instr_ready back after one cycle.
REQ-032 SHALL test acc=0x0001, DEC -> acc=0x0000, flag_z=1; then JMP -> acc and flags unchanged, no strobes.
REQ-033 SHALL test back-to-back instr_valid=1 during busy -> second instruction accepted only in IDLE, none dropped or duplicated.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared instruction set for the execution controller: opcode values used by
// the controller, its decoder and the downstream ALU.
package exec_ctrl_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ST  = 8'h02;
  localparam logic [7:0] OP_LDI = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_SUB = 8'h05;
  localparam logic [7:0] OP_AND = 8'h06;
  localparam logic [7:0] OP_OR  = 8'h07;
  localparam logic [7:0] OP_XOR = 8'h08;
  localparam logic [7:0] OP_NOT = 8'h09;
  localparam logic [7:0] OP_RR  = 8'h0A;
  localparam logic [7:0] OP_RL  = 8'h0B;
  localparam logic [7:0] OP_INC = 8'h0C;
  localparam logic [7:0] OP_DEC = 8'h0D;
  localparam logic [7:0] OP_RST = 8'h0E;
  localparam logic [7:0] OP_JMP = 8'h0F;
  localparam logic [7:0] OP_JMA = 8'h10;
  localparam logic [7:0] OP_CLL = 8'h11;
  localparam logic [7:0] OP_RET = 8'h12;
  localparam logic [7:0] OP_IOR = 8'h13;
  localparam logic [7:0] OP_IOW = 8'h14;

endpackage

// File: rtl/exec_ctrl_decode.sv
// Opcode classification: which opcodes fetch an operand, store the accumulator,
// update the accumulator, and target the I/O space instead of memory.
module exec_decode
  import exec_ctrl_pkg::*;
(
  input  logic [7:0] i_op,
  output logic       o_needs_read,
  output logic       o_needs_write,
  output logic       o_writes_acc,
  output logic       o_is_io
);

  always_comb begin
    o_needs_read  = 1'b0;
    o_needs_write = 1'b0;
    o_writes_acc  = 1'b0;
    o_is_io       = 1'b0;
    case (i_op)
      OP_XOR, OP_OR, OP_AND, OP_SUB, OP_ADD, OP_LD: begin
        o_needs_read = 1'b1;
        o_writes_acc = 1'b1;
      end
      OP_IOR: begin
        o_needs_read = 1'b1;
        o_writes_acc = 1'b1;
        o_is_io      = 1'b1;
      end
      OP_ST: begin
        o_needs_write = 1'b1;
      end
      OP_IOW: begin
        o_needs_write = 1'b1;
        o_is_io       = 1'b1;
      end
      OP_NOT, OP_RR, OP_RL, OP_DEC, OP_INC, OP_LDI, OP_RST: begin
        o_writes_acc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Accumulator execution controller: accepts one instruction at a time, sequences
// an optional memory/IO read or write, and drives an external ALU.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       instr_op,
  input  logic [WIDTH-1:0] instr_arg,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [7:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             io_rd,
  output logic             io_wr,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_n,
  output logic             busy
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // RD    | one-cycle memory/IO read strobe at arg
  // EXEC  | ALU operation; acc written at end of cycle if the op updates it
  // WR    | one-cycle memory/IO write strobe of acc at arg
  typedef enum logic [1:0] {S_IDLE, S_RD, S_EXEC, S_WR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_op;
  logic [WIDTH-1:0] r_arg;
  logic [WIDTH-1:0] r_acc;
  logic             r_z;
  logic             r_n;

  logic [7:0]       w_dec_op;
  logic             w_needs_read;
  logic             w_needs_write;
  logic             w_writes_acc;
  logic             w_is_io;
  logic             w_accept;

  // In IDLE the incoming opcode is classified for routing; afterwards the latched one.
  assign w_dec_op = (r_state == S_IDLE) ? instr_op : r_op;

  exec_decode u_decode (
    .i_op          (w_dec_op),
    .o_needs_read  (w_needs_read),
    .o_needs_write (w_needs_write),
    .o_writes_acc  (w_writes_acc),
    .o_is_io       (w_is_io)
  );

  assign w_accept = (r_state == S_IDLE) && instr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    io_rd       = 1'b0;
    io_wr       = 1'b0;
    alu_op      = OP_NOP;
    alu_in1     = r_acc;
    alu_in2     = r_arg;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (w_needs_read) begin
            w_next = S_RD;
          end else if (w_needs_write) begin
            w_next = S_WR;
          end else begin
            w_next = S_EXEC;
          end
        end
      end
      S_RD: begin
        mem_rd = !w_is_io;
        io_rd  = w_is_io;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        alu_op  = r_op;
        alu_in1 = (r_op == OP_LDI) ? r_arg : r_acc;
        // Only read-path ops pass through RD, so needs_read identifies that entry.
        alu_in2 = w_needs_read ? mem_rdata : r_arg;
        w_next  = S_IDLE;
      end
      S_WR: begin
        mem_wr = !w_is_io;
        io_wr  = w_is_io;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_NOP;
      r_arg <= '0;
      r_acc <= '0;
      r_z   <= 1'b1;
      r_n   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= instr_op;
        r_arg <= instr_arg;
      end
      if ((r_state == S_EXEC) && w_writes_acc) begin
        r_acc <= alu_out;
        r_z   <= (alu_out == '0);
        r_n   <= alu_out[WIDTH-1];
      end
    end
  end

  assign mem_addr  = r_arg;
  assign mem_wdata = r_acc;
  assign acc       = r_acc;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl with a behavioural ALU and a 1-cycle-latency
// memory/IO model; expectations are queued at issue and checked by a monitor.
module tb_exec_ctrl;
  import exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  instr_op = OP_NOP;
  logic [15:0] instr_arg = '0;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [7:0]  alu_op;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, io_rd, io_wr;
  logic [15:0] acc;
  logic        flag_z, flag_n, busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [15:0] acc; int lat; } res_t;
  typedef struct { int kind; logic [15:0] addr; logic [15:0] data; } str_t;
  typedef struct { logic [7:0] op; logic [15:0] in1; logic [15:0] in2; } alu_t;

  res_t q_res[$];
  str_t q_str[$];
  alu_t q_alu[$];

  logic [15:0] mem [0:255];
  logic [15:0] io  [0:255];

  always #5 clk = ~clk;

  exec_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_arg   (instr_arg),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .io_rd       (io_rd),
    .io_wr       (io_wr),
    .acc         (acc),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .busy        (busy)
  );

  always_comb begin
    alu_out = 16'hDEAD;
    case (alu_op)
      OP_LDI:        alu_out = alu_in1;
      OP_LD, OP_IOR: alu_out = alu_in2;
      OP_ADD:        alu_out = alu_in1 + alu_in2;
      OP_SUB:        alu_out = alu_in1 - alu_in2;
      OP_AND:        alu_out = alu_in1 & alu_in2;
      OP_OR:         alu_out = alu_in1 | alu_in2;
      OP_XOR:        alu_out = alu_in1 ^ alu_in2;
      OP_NOT:        alu_out = ~alu_in1;
      OP_INC:        alu_out = alu_in1 + 16'd1;
      OP_DEC:        alu_out = alu_in1 - 16'd1;
      OP_RR:         alu_out = {alu_in1[0], alu_in1[15:1]};
      OP_RL:         alu_out = {alu_in1[14:0], alu_in1[15]};
      OP_RST:        alu_out = 16'h0000;
      default:       alu_out = 16'hDEAD;
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h10] <= 16'h0003;
      mem[8'h20] <= 16'h0000;
      io[8'h03]  <= 16'h00F0;
      io[8'h07]  <= 16'h0000;
      mem_rdata  <= 16'h0000;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
      else if (io_rd) mem_rdata <= io[mem_addr[7:0]];
      if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
      if (io_wr) io[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    int   busy_cnt;
    int   k, cnt;
    res_t r;
    str_t s;
    alu_t a;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        continue;
      end
      cnt = int'(mem_rd) + int'(io_rd) + int'(mem_wr) + int'(io_wr);
      k = mem_rd ? 1 : io_rd ? 2 : mem_wr ? 3 : io_wr ? 4 : 0;
      if (cnt > 0) begin
        chk("strobe_onehot", 32'(cnt), 32'd1);
        if (q_str.size() == 0) begin
          chk("strobe_unexpected", 32'(k), 32'd0);
        end else begin
          s = q_str.pop_front();
          chk("strobe_kind", 32'(k), 32'(s.kind));
          chk("strobe_addr", 32'(mem_addr), 32'(s.addr));
          if (k >= 3) chk("strobe_wdata", 32'(mem_wdata), 32'(s.data));
        end
      end
      if (alu_op != OP_NOP) begin
        if (q_alu.size() == 0) begin
          chk("alu_unexpected", 32'(alu_op), 32'(OP_NOP));
        end else begin
          a = q_alu.pop_front();
          chk("alu_op", 32'(alu_op), 32'(a.op));
          chk("alu_in1", 32'(alu_in1), 32'(a.in1));
          chk("alu_in2", 32'(alu_in2), 32'(a.in2));
        end
      end
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (q_res.size() == 0) begin
          chk("result_unexpected", 32'(busy_cnt), 32'd0);
        end else begin
          r = q_res.pop_front();
          chk("acc", 32'(acc), 32'(r.acc));
          chk("flag_z", 32'(flag_z), 32'(r.acc == 16'h0000));
          chk("flag_n", 32'(flag_n), 32'(r.acc[15]));
          chk("busy_cycles", 32'(busy_cnt), 32'(r.lat));
        end
        busy_cnt = 0;
      end
    end
  endtask

  // kind: 0 none, 1 mem_rd, 2 io_rd, 3 mem_wr, 4 io_wr
  task automatic issue(input logic [7:0] op, input logic [15:0] arg, input int kind,
                       input logic [15:0] e1, input logic [15:0] e2,
                       input logic [15:0] eacc, input int lat);
    int guard;
    @(negedge clk);
    q_res.push_back('{acc: eacc, lat: lat});
    if (kind != 0) q_str.push_back('{kind: kind, addr: arg, data: eacc});
    if (kind < 3) q_alu.push_back('{op: op, in1: e1, in2: e2});
    instr_valid = 1'b1;
    instr_op    = op;
    instr_arg   = arg;
    guard = 0;
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) chk("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
  endtask

  task automatic check_idle_reset_state(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'h0);
    chk({tag, "_flag_z"}, 32'(flag_z), 32'd1);
    chk({tag, "_flag_n"}, 32'(flag_n), 32'd0);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_strobes"}, 32'({mem_rd, mem_wr, io_rd, io_wr}), 32'h0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'(OP_NOP));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_idle_reset_state("reset");
    rst_n = 1'b1;

    // Back-to-back stream: instr_valid stays high across busy periods.
    issue(OP_LDI, 16'h1234, 0, 16'h1234, 16'h1234, 16'h1234, 1);
    issue(OP_LDI, 16'h0005, 0, 16'h0005, 16'h0005, 16'h0005, 1);
    issue(OP_ADD, 16'h0010, 1, 16'h0005, 16'h0003, 16'h0008, 2);
    issue(OP_LDI, 16'h8000, 0, 16'h8000, 16'h8000, 16'h8000, 1);
    issue(OP_ST,  16'h0020, 3, 16'h0000, 16'h0000, 16'h8000, 1);
    issue(OP_LD,  16'h0020, 1, 16'h8000, 16'h8000, 16'h8000, 2);
    issue(OP_LDI, 16'h0001, 0, 16'h0001, 16'h0001, 16'h0001, 1);
    issue(OP_DEC, 16'h0000, 0, 16'h0001, 16'h0000, 16'h0000, 1);
    issue(OP_JMP, 16'h0040, 0, 16'h0000, 16'h0040, 16'h0000, 1);
    issue(OP_IOR, 16'h0003, 2, 16'h0000, 16'h00F0, 16'h00F0, 2);
    issue(OP_IOW, 16'h0007, 4, 16'h0000, 16'h0000, 16'h00F0, 1);
    issue(OP_XOR, 16'h0010, 1, 16'h00F0, 16'h0003, 16'h00F3, 2);
    issue(OP_NOT, 16'h0000, 0, 16'h00F3, 16'h0000, 16'hFF0C, 1);
    issue(OP_INC, 16'h0000, 0, 16'hFF0C, 16'h0000, 16'hFF0D, 1);
    issue(OP_RL,  16'h0000, 0, 16'hFF0D, 16'h0000, 16'hFE1B, 1);
    issue(OP_RR,  16'h0000, 0, 16'hFE1B, 16'h0000, 16'hFF0D, 1);
    issue(8'hFF,  16'h0055, 0, 16'hFF0D, 16'h0055, 16'hFF0D, 1);
    issue(OP_RET, 16'h0066, 0, 16'hFF0D, 16'h0066, 16'hFF0D, 1);
    issue(OP_RST, 16'h0000, 0, 16'hFF0D, 16'h0000, 16'h0000, 1);
    issue(OP_SUB, 16'h0010, 1, 16'h0000, 16'h0003, 16'hFFFD, 2);
    issue(OP_OR,  16'h0010, 1, 16'hFFFD, 16'h0003, 16'hFFFF, 2);
    issue(OP_AND, 16'h0010, 1, 16'hFFFF, 16'h0003, 16'h0003, 2);
    issue(OP_IOR, 16'h0007, 2, 16'h0003, 16'h00F0, 16'h00F0, 2);
    @(negedge clk);
    instr_valid = 1'b0;

    // Reset while the read strobe of an ADD is active.
    issue(OP_LDI, 16'h00AA, 0, 16'h00AA, 16'h00AA, 16'h00AA, 1);
    issue(OP_ADD, 16'h0010, 1, 16'h00AA, 16'h0003, 16'h00AD, 2);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("rd_before_reset", 32'(mem_rd), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_reset_state("midrd_reset");
    q_res.delete();
    q_alu.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OP_LDI, 16'h0042, 0, 16'h0042, 16'h0042, 16'h0042, 1);
    @(negedge clk);
    instr_valid = 1'b0;

    guard = 0;
    while ((q_res.size() != 0 || busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("drain_results", 32'(q_res.size()), 32'd0);
    chk("drain_strobes", 32'(q_str.size()), 32'd0);
    chk("drain_alu", 32'(q_alu.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
